// File: rtl/mult32_seq_unit_if.sv
// Request/response bundle for the sequential RV32M multiply unit.
// The master side issues operands and consumes results; the slave side is the unit.
interface mult32_seq_unit_if #(
   parameter int unsigned XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [1:0]      op;
   logic [XLEN-1:0] operand_a;
   logic [XLEN-1:0] operand_b;
   logic            kill;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;

   modport master (
      output in_valid, op, operand_a, operand_b, kill, out_ready,
      input  in_ready, out_valid, result
   );

   modport slave (
      input  in_valid, op, operand_a, operand_b, kill, out_ready,
      output in_ready, out_valid, result
   );
endinterface

// File: rtl/mult32_seq_unit.sv
// Four-cycle 32x32 multiply (MUL/MULH/MULHSU/MULHU) built around one 16x16
// unsigned multiplier; operands are made unsigned, summed, then re-signed.
module Mult16U #(
   parameter int unsigned HALF = 16
) (
   input  logic [HALF-1:0]   i_a,
   input  logic [HALF-1:0]   i_b,
   output logic [2*HALF-1:0] o_p
);
   assign o_p = i_a * i_b;
endmodule

module mult32_seq_unit #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned HALF = XLEN / 2
) (
   input logic               clk,
   input logic               rst,
   mult32_seq_unit_if.slave  bus
);
   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] MUL0 = 3'd1;
   localparam logic [2:0] MUL1 = 3'd2;
   localparam logic [2:0] MUL2 = 3'd3;
   localparam logic [2:0] MUL3 = 3'd4;
   localparam logic [2:0] SIGN = 3'd5;
   localparam logic [2:0] DONE = 3'd6;

   localparam logic [1:0] OP_MUL    = 2'b00;
   localparam logic [1:0] OP_MULH   = 2'b01;
   localparam logic [1:0] OP_MULHSU = 2'b10;

   logic [2:0]        r_state;
   logic [2:0]        w_state_nxt;
   logic [XLEN-1:0]   r_a_mag;
   logic [XLEN-1:0]   r_b_mag;
   logic              r_neg;
   logic [1:0]        r_op;
   logic [2*XLEN-1:0] r_acc;
   logic [XLEN-1:0]   r_result;

   logic              w_accept;
   logic              w_a_signed;
   logic              w_b_signed;
   logic              w_a_neg;
   logic              w_b_neg;
   logic [XLEN-1:0]   w_a_mag;
   logic [XLEN-1:0]   w_b_mag;
   logic [HALF-1:0]   w_mul_a;
   logic [HALF-1:0]   w_mul_b;
   logic [2*HALF-1:0] w_pp;
   logic [2*XLEN-1:0] w_pp_shift;
   logic [2*XLEN-1:0] w_acc_fix;
   logic [XLEN-1:0]   w_result_sel;

   assign bus.in_ready  = (r_state == IDLE) && !rst;
   assign bus.out_valid = (r_state == DONE);
   assign bus.result    = r_result;

   assign w_accept = (r_state == IDLE) && bus.in_valid && !bus.kill;

   // 0x80000000 negates to itself, which is the correct unsigned magnitude.
   assign w_a_signed = (bus.op == OP_MULH) || (bus.op == OP_MULHSU);
   assign w_b_signed = (bus.op == OP_MULH);
   assign w_a_neg    = w_a_signed && bus.operand_a[XLEN-1];
   assign w_b_neg    = w_b_signed && bus.operand_b[XLEN-1];
   assign w_a_mag    = w_a_neg ? (~bus.operand_a + 1'b1) : bus.operand_a;
   assign w_b_mag    = w_b_neg ? (~bus.operand_b + 1'b1) : bus.operand_b;

   always_comb begin
      w_mul_a = r_a_mag[HALF-1:0];
      w_mul_b = r_b_mag[HALF-1:0];
      if ((r_state == MUL2) || (r_state == MUL3)) begin
         w_mul_a = r_a_mag[XLEN-1:HALF];
      end
      if ((r_state == MUL1) || (r_state == MUL3)) begin
         w_mul_b = r_b_mag[XLEN-1:HALF];
      end
   end

   Mult16U #(.HALF(HALF)) u_mult16 (
      .i_a (w_mul_a),
      .i_b (w_mul_b),
      .o_p (w_pp)
   );

   always_comb begin
      w_pp_shift = '0;
      case (r_state)
         MUL0:       w_pp_shift = {{XLEN{1'b0}}, w_pp};
         MUL1, MUL2: w_pp_shift = {{HALF{1'b0}}, w_pp, {HALF{1'b0}}};
         MUL3:       w_pp_shift = {w_pp, {XLEN{1'b0}}};
         default:    w_pp_shift = '0;
      endcase
   end

   assign w_acc_fix    = r_neg ? (~r_acc + 1'b1) : r_acc;
   assign w_result_sel = (r_op == OP_MUL) ? w_acc_fix[XLEN-1:0] : w_acc_fix[2*XLEN-1:XLEN];

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_nxt = MUL0;
         MUL0:    w_state_nxt = MUL1;
         MUL1:    w_state_nxt = MUL2;
         MUL2:    w_state_nxt = MUL3;
         MUL3:    w_state_nxt = SIGN;
         SIGN:    w_state_nxt = DONE;
         DONE:    if (bus.out_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
      // Flush wins over everything, including a consumer accepting in DONE.
      if (bus.kill && (r_state != IDLE)) begin
         w_state_nxt = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_a_mag  <= '0;
         r_b_mag  <= '0;
         r_neg    <= 1'b0;
         r_op     <= '0;
         r_acc    <= '0;
         r_result <= '0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_a_mag <= w_a_mag;
                  r_b_mag <= w_b_mag;
                  r_neg   <= w_a_neg ^ w_b_neg;
                  r_op    <= bus.op;
                  r_acc   <= '0;
               end
            end
            MUL0, MUL1, MUL2, MUL3: begin
               r_acc <= r_acc + w_pp_shift;
            end
            SIGN: begin
               if (!bus.kill) begin
                  r_acc    <= w_acc_fix;
                  r_result <= w_result_sel;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mult32_seq_unit.sv
// Directed checks of mult32_seq_unit: products, latency, backpressure,
// kill in several states and reset mid-operation.
module tb_mult32_seq_unit;
   logic clk;
   logic rst;
   int   n_chk;
   int   n_pass;

   mult32_seq_unit_if #(.XLEN(32)) u_bus ();

   mult32_seq_unit #(.XLEN(32), .HALF(16)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench at #1 after the accept edge (unit now in MUL0).
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      int unsigned guard;
      guard = 0;
      while (!u_bus.in_ready && guard < 20) begin
         tick();
         guard++;
      end
      chk("issue_ready", u_bus.in_ready, 1'b1);
      u_bus.in_valid  = 1'b1;
      u_bus.op        = op;
      u_bus.operand_a = a;
      u_bus.operand_b = b;
      tick();
      u_bus.in_valid  = 1'b0;
      u_bus.operand_a = 32'hDEAD_BEEF;
      u_bus.operand_b = 32'hCAFE_F00D;
   endtask

   task automatic wait_valid(output int unsigned lat);
      lat = 0;
      while (!u_bus.out_valid && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp);
      int unsigned lat;
      issue(op, a, b);
      wait_valid(lat);
      chk({tag, "_valid"}, u_bus.out_valid, 1'b1);
      chk(tag, u_bus.result, exp);
      tick();
   endtask

   initial begin
      int unsigned lat;
      int unsigned seen;
      n_chk  = 0;
      n_pass = 0;
      rst             = 1'b1;
      u_bus.in_valid  = 1'b0;
      u_bus.op        = 2'b00;
      u_bus.operand_a = '0;
      u_bus.operand_b = '0;
      u_bus.kill      = 1'b0;
      u_bus.out_ready = 1'b1;
      tick();
      tick();
      chk("rst_in_ready", u_bus.in_ready, 1'b0);
      chk("rst_out_valid", u_bus.out_valid, 1'b0);
      chk("rst_result", u_bus.result, 32'h0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", u_bus.in_ready, 1'b1);

      // Accept edge ends cycle T; DONE is cycle T+6, i.e. 5 edges after accept.
      issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_valid(lat);
      chk("latency", lat, 5);
      chk("mulhu_ff_ff", u_bus.result, 32'hFFFF_FFFE);
      tick();

      run("mul_ff_ff",      2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
      run("mulh_min_min",   2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
      run("mulh_m1_1",      2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF);
      run("mulh_m1_0",      2'b01, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000);
      run("mulhsu_m1_ff",   2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run("mulhsu_2_min",   2'b10, 32'h0000_0002, 32'h8000_0000, 32'h0000_0001);
      run("mul_m3_5",       2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1);
      run("mulh_m3_5",      2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF);
      run("mulhu_m3_5",     2'b11, 32'hFFFF_FFFD, 32'h0000_0005, 32'h0000_0004);

      // Backpressure: result and valid held, no new request accepted.
      u_bus.out_ready = 1'b0;
      issue(2'b00, 32'h0001_2345, 32'h0001_0000);
      wait_valid(lat);
      for (int i = 0; i < 3; i++) begin
         chk("bp_valid", u_bus.out_valid, 1'b1);
         chk("bp_result", u_bus.result, 32'h2345_0000);
         chk("bp_in_ready", u_bus.in_ready, 1'b0);
         tick();
      end
      u_bus.out_ready = 1'b1;
      tick();
      chk("bp_release_valid", u_bus.out_valid, 1'b0);
      chk("bp_release_in_ready", u_bus.in_ready, 1'b1);

      // Kill while in MUL2.
      issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      tick();
      tick();
      u_bus.kill = 1'b1;
      tick();
      u_bus.kill = 1'b0;
      chk("kill_in_ready", u_bus.in_ready, 1'b1);
      chk("kill_out_valid", u_bus.out_valid, 1'b0);
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (u_bus.out_valid) seen++;
         tick();
      end
      chk("kill_no_pulse", seen, 0);
      run("mulhu_after_kill", 2'b11, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001);

      // Kill in IDLE blocks acceptance.
      u_bus.kill     = 1'b1;
      u_bus.in_valid = 1'b1;
      tick();
      u_bus.kill     = 1'b0;
      u_bus.in_valid = 1'b0;
      chk("kill_idle_in_ready", u_bus.in_ready, 1'b1);

      // Kill beats out_ready in DONE.
      u_bus.out_ready = 1'b0;
      issue(2'b00, 32'h0000_0007, 32'h0000_0006);
      wait_valid(lat);
      chk("kill_done_result", u_bus.result, 32'h0000_002A);
      u_bus.kill      = 1'b1;
      u_bus.out_ready = 1'b1;
      tick();
      u_bus.kill = 1'b0;
      chk("kill_done_valid", u_bus.out_valid, 1'b0);
      chk("kill_done_in_ready", u_bus.in_ready, 1'b1);

      // Reset while in SIGN; a concurrent request must be ignored.
      issue(2'b01, 32'hFFFF_FFFF, 32'h0000_0001);
      tick();
      tick();
      tick();
      tick();
      chk("sign_not_valid", u_bus.out_valid, 1'b0);
      rst             = 1'b1;
      u_bus.in_valid  = 1'b1;
      u_bus.op        = 2'b11;
      u_bus.operand_a = 32'h0000_0003;
      u_bus.operand_b = 32'h0000_0003;
      tick();
      rst            = 1'b0;
      u_bus.in_valid = 1'b0;
      #1;
      chk("rst_sign_in_ready", u_bus.in_ready, 1'b1);
      chk("rst_sign_out_valid", u_bus.out_valid, 1'b0);
      chk("rst_sign_result", u_bus.result, 32'h0);
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (u_bus.out_valid) seen++;
      end
      chk("rst_sign_no_pulse", seen, 0);

      run("mul_after_rst", 2'b00, 32'h0000_0003, 32'h0000_0003, 32'h0000_0009);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
